// File: rtl/lane_sched_pkg.sv
// Shared types, constants and the lane period function for the lane scheduler.
// Lane 0 drives display row 1 through lane 6 on row 13.
package lane_sched_pkg;

  localparam int NUM_LANES  = 7;
  localparam int CNT_W      = 10;
  localparam int LVL_W      = 3;
  localparam int MAX_LEVEL  = 7;
  localparam int SPEEDUP    = 50;
  localparam int MIN_PERIOD = 50;
  localparam int CALC_W     = CNT_W + LVL_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] BASE_PERIOD [NUM_LANES] =
    '{10'd600, 10'd500, 10'd400, 10'd300, 10'd200, 10'd100, 10'd700};

  // Widened so base - level*SPEEDUP cannot wrap; the floor is applied before narrowing.
  function automatic logic [CNT_W-1:0] lane_period(input int unsigned lane,
                                                   input logic [LVL_W-1:0] lvl);
    logic [CALC_W-1:0] base;
    logic [CALC_W-1:0] cut;
    logic [CALC_W-1:0] floor_v;
    logic [CALC_W-1:0] result;
    base    = CALC_W'(BASE_PERIOD[lane]);
    cut     = CALC_W'(lvl) * CALC_W'(SPEEDUP);
    floor_v = CALC_W'(MIN_PERIOD);
    if (base >= cut + floor_v) result = base - cut;
    else                       result = floor_v;
    return result[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/lane_timer.sv
// Per-lane down-counter: issues a registered one-cycle step every load_val cycles
// while enabled; load restarts the count without stepping.
module lane_timer
  import lane_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             step
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (enable) begin
      if (cnt_q == CNT_W'(1)) begin
        cnt_d  = load_val;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/lane_scheduler.sv
// Game-state FSM and difficulty level for the road-crossing car lanes; fans out
// load/enable to one lane_timer per lane.
module lane_scheduler
  import lane_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 lost,
  input  logic                 level_up,
  output logic [NUM_LANES-1:0] step,
  output logic [1:0]           state,
  output logic [LVL_W-1:0]     level,
  output logic                 running
);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             lane_load;
  logic             lane_en;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    lane_load = 1'b0;
    lane_en   = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (start) begin
          state_d   = RUN;
          level_d   = '0;
          lane_load = 1'b1;
        end
      end
      RUN: begin
        // lost outranks level_up; frozen counters simply see neither load nor enable.
        if (lost) begin
          state_d = HOLD;
        end else if (level_up) begin
          if (level_q != LVL_W'(MAX_LEVEL)) level_d = level_q + LVL_W'(1);
          lane_load = 1'b1;
        end else begin
          lane_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // level_d equals level_q except on a load, so one reload value serves both cases.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [CNT_W-1:0] reload_val;
    assign reload_val = lane_period(i, level_d);

    lane_timer u_lane_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (lane_load),
      .load_val (reload_val),
      .enable   (lane_en),
      .step     (step[i])
    );
  end

  assign state   = state_q;
  assign level   = level_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_lane_scheduler.sv
// Scoreboard bench for lane_scheduler: the driver queues the edge at which each
// lane must strobe; a negedge monitor compares every lane every cycle.
module tb_lane_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic       lost;
  logic       level_up;
  logic [6:0] step;
  logic [1:0] state;
  logic [2:0] level;
  logic       running;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int exp_q [7][$];

  // Hand-computed lane periods at levels 0, 1 and 7 (floor 50).
  localparam int P_L0 [7] = '{600, 500, 400, 300, 200, 100, 700};
  localparam int P_L1 [7] = '{550, 450, 350, 250, 150,  50, 650};
  localparam int P_L7 [7] = '{250, 150,  50,  50,  50,  50, 350};

  lane_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .lost     (lost),
    .level_up (level_up),
    .step     (step),
    .state    (state),
    .level    (level),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: a lane must strobe exactly at the queued edges and nowhere else.
  always @(negedge clk) begin
    for (int l = 0; l < 7; l++) begin
      logic exp_b;
      exp_b = 1'b0;
      if (exp_q[l].size() > 0 && exp_q[l][0] == edge_n) begin
        exp_b = 1'b1;
        void'(exp_q[l].pop_front());
      end
      n_tests++;
      if (step[l] !== exp_b) begin
        n_fail++;
        $display("FAIL step[%0d] at edge %0d: got %b expected %b", l, edge_n, step[l], exp_b);
      end
    end
  end

  // Queue strobes for lanes reloaded at load_edge, up to and including edge last.
  task automatic expect_run(input int load_edge, input int per [7], input int last);
    for (int l = 0; l < 7; l++)
      for (int t = load_edge + per[l]; t <= last; t += per[l])
        exp_q[l].push_back(t);
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = edge_n + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int s1, s2, s3, lv, rr;

  initial begin
    reset = 1'b0; start = 1'b0; lost = 1'b0; level_up = 1'b0;
    repeat (3) @(negedge clk);
    check("reset state", int'(state), 0);
    check("reset level", int'(level), 0);
    check("reset running", int'(running), 0);
    check("reset step", int'(step), 0);
    reset = 1'b1;

    // IDLE: no strobes, lost/level_up ignored.
    repeat (500) @(negedge clk);
    level_up = 1'b1; @(negedge clk); level_up = 1'b0;
    lost = 1'b1; @(negedge clk); lost = 1'b0;
    repeat (500) @(negedge clk);
    check("idle state", int'(state), 0);
    check("idle level", int'(level), 0);

    // Level-0 run; a start mid-run is ignored; plain lost moves to HOLD.
    pulse_start(s1);
    expect_run(s1, P_L0, s1 + 1499);
    check("run state", int'(state), 1);
    check("run running", int'(running), 1);
    check("run level", int'(level), 0);
    wait_edge(s1 + 749);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("start ignored in run", int'(state), 1);
    wait_edge(s1 + 1499);
    lost = 1'b1;
    @(negedge clk);
    check("lost to hold", int'(state), 2);
    check("hold running", int'(running), 0);
    repeat (100) @(negedge clk);
    lost = 1'b0;
    check("hold stays", int'(state), 2);

    // Restart from HOLD, level_up at entry+230, then 8 pulses to saturate.
    pulse_start(s2);
    check("restart state", int'(state), 1);
    expect_run(s2, P_L0, s2 + 229);
    wait_edge(s2 + 229);
    level_up = 1'b1; @(negedge clk); level_up = 1'b0;
    lv = s2 + 230;
    check("level after up", int'(level), 1);
    expect_run(lv, P_L1, lv + 799);
    wait_edge(lv + 799);
    level_up = 1'b1;
    repeat (6) @(negedge clk);
    check("level reaches max", int'(level), 7);
    repeat (2) @(negedge clk);
    level_up = 1'b0;
    rr = lv + 807;
    check("level saturated", int'(level), 7);
    expect_run(rr, P_L7, rr + 399);

    // lost together with level_up: HOLD wins, level unchanged.
    wait_edge(rr + 399);
    lost = 1'b1; level_up = 1'b1;
    @(negedge clk);
    level_up = 1'b0;
    check("lost+up state", int'(state), 2);
    check("lost+up level", int'(level), 7);
    repeat (500) @(negedge clk);
    lost = 1'b0;
    check("long hold level", int'(level), 7);

    // Restart, then async reset during the first lane-5 strobe.
    pulse_start(s3);
    check("restart level", int'(level), 0);
    expect_run(s3, P_L0, s3 + 100);
    wait_edge(s3 + 100);
    #1;
    check("strobe before reset", int'(step), 7'b0100000);
    reset = 1'b0;
    #1;
    check("async step clear", int'(step), 0);
    check("async state", int'(state), 0);
    check("async level", int'(level), 0);
    check("async running", int'(running), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    check("post-reset idle", int'(state), 0);

    for (int l = 0; l < 7; l++) check($sformatf("lane %0d pending", l), exp_q[l].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
